tlp_tx_arbiter: RTL
===================

TLP_TX_ARBITER -- requirements
Module: tlp_tx_arbiter

Interface
REQ-001 Parameter pENGINENUM, default 4, is the number of requesting engines (2..8).
REQ-002 Parameter pDW, default 64, is the TLP data width in bits.
REQ-003 Parameter pTIMEOUT, default 1023, is the maximum number of stalled cycles allowed while a grant is held (1..65535).
REQ-004 Port i_Clk, input, 1 bit, is the clock; all logic is rising-edge.
REQ-005 Port i_ARst, input, 1 bit, is the reset: asynchronous, active-high.
REQ-006 Port iv_EngineReq, input, pENGINENUM bits, flags a complete TLP queued in engine n.
REQ-007 Ports iv_EngineSop, iv_EngineEop and iv_EngineDv, inputs, pENGINENUM bits each, are the per-engine start, end and valid strobes.
REQ-008 Port iv_EngineData, input, pENGINENUM*pDW bits, carries engine n data in slice [n*pDW +: pDW].
REQ-009 Port ov_EngineGnt, output, pENGINENUM bits, registered, is the one-hot grant.
REQ-010 Port ov_EngineRd, output, pENGINENUM bits, is the per-engine beat-consumed strobe.
REQ-011 Ports o_TxSop, o_TxEop and o_TxDv, outputs, 1 bit each, are the strobes to the core Tx interface.
REQ-012 Port o_TxData, output, pDW bits, is the Tx data.
REQ-013 Port i_TxReady, input, 1 bit, is the core Tx backpressure; 1 = beat accepted.
REQ-014 Port o_TimeoutErr, output, 1 bit, registered, is a one-cycle abort pulse.
REQ-015 Port o_Busy, output, 1 bit, is 1 while a grant is held.

Function
REQ-016 The FSM SHALL have states IDLE and XFER.
REQ-017 In IDLE with iv_EngineReq != 0, the FSM SHALL register a one-hot grant on the next edge and enter XFER, giving 1-cycle request-to-grant latency.
REQ-018 Arbitration SHALL be round-robin, searching upward with wrap starting at rr_ptr; rr_ptr SHALL be (last granted index + 1) mod pENGINENUM.
REQ-019 In XFER, o_TxDv, o_TxSop, o_TxEop and o_TxData SHALL be the combinational mux of the granted engine's signals, with o_TxDv = |(ov_EngineGnt & iv_EngineDv).
REQ-020 When no grant is held, the Tx outputs SHALL be 0 and o_TxData SHALL be all-zero.
REQ-021 ov_EngineRd SHALL equal ov_EngineGnt & iv_EngineDv & {pENGINENUM{i_TxReady}}.
REQ-022 A beat whose o_TxEop, o_TxDv and i_TxReady are all 1 SHALL clear ov_EngineGnt, update rr_ptr and return the FSM to IDLE on the next edge, leaving one bubble cycle between packets.
REQ-023 A single-beat TLP (Sop and Eop on the same beat) SHALL be supported.
REQ-024 Deassertion of the granted engine's iv_EngineReq during XFER SHALL be ignored; the grant holds until EOP or timeout.
REQ-025 Eop without Dv, or Dv without i_TxReady, SHALL NOT end the transfer.
REQ-026 Requests arriving during XFER SHALL wait; simultaneous requests SHALL be resolved by rr_ptr only.
REQ-027 Stall counter: it SHALL clear on grant and on every accepted beat, and increment otherwise while in XFER.
REQ-028 When the stall counter reaches pTIMEOUT, the block SHALL drop the grant, pulse o_TimeoutErr for one cycle, advance rr_ptr and return to IDLE.
REQ-029 o_Busy SHALL be 1 exactly while the FSM is in XFER.

Reset
REQ-030 On i_ARst, the FSM SHALL go to IDLE, and ov_EngineGnt, rr_ptr, the stall counter and o_TimeoutErr SHALL be 0.
REQ-031 Reset asserted during XFER SHALL abort the transfer immediately, with the Tx outputs at 0 the same cycle.
REQ-032 After reset, the first grant SHALL go to the lowest requesting index.

Structure
REQ-033 Package tlp_tx_pkg SHALL hold the FSM state type and the default pDW and pTIMEOUT constants.
REQ-034 The round-robin pick SHALL be a sub-module rr_arbiter with inputs req and ptr and a one-hot gnt output, all combinational.

Verification
REQ-035 With Req=4'b0110 after reset, the grant SHALL go to engine 1; after its EOP and one bubble cycle, the grant SHALL go to engine 2.
REQ-036 With all four engines requesting 3-beat TLPs continuously, the grant order SHALL be 0,1,2,3,0 with exactly 1 idle cycle between packets.
REQ-037 A single-beat TLP from engine 3 with i_TxReady=1 SHALL produce o_TxSop=o_TxEop=o_TxDv=1 for one cycle and a grant of 2 cycles total.
REQ-038 Holding i_TxReady=0 for 5 cycles mid-packet SHALL stall the packet with ov_EngineRd=0, and the data SHALL resume intact.
REQ-039 With pTIMEOUT=8 and the granted engine holding Dv=0, o_TimeoutErr SHALL pulse on the 8th stalled cycle, the grant SHALL drop and the next requester SHALL be granted.
REQ-040 Asserting i_ARst during beat 2 of 4 SHALL clear the grant and Tx outputs asynchronously, and the post-reset grant SHALL go to index 0.

Source files
------------

// File: rtl/tlp_tx_pkg.sv
// ---------------------------------------------------------------------------
// tlp_tx_pkg
// Shared types and defaults for the TLP transmit arbiter.
//   state_e          : arbiter FSM state encoding
//   DEFAULT_DW       : default TLP data width (bits)
//   DEFAULT_TIMEOUT  : default stall limit while a grant is held (cycles)
//   STALL_W          : stall counter width, sized for the largest legal limit
// ---------------------------------------------------------------------------
package tlp_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int DEFAULT_DW      = 64;
  localparam int DEFAULT_TIMEOUT = 1023;
  localparam int STALL_W         = 16;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches upward from ptr with wrap and
// returns a one-hot grant for the first requester found (all zero if none).
//   req : request vector, one bit per engine
//   ptr : index where the search starts
//   gnt : one-hot grant
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int pN  = 4,
  parameter int pPW = 2
) (
  input  logic [pN-1:0]  req,
  input  logic [pPW-1:0] ptr,
  output logic [pN-1:0]  gnt
);

  logic found;

  // Outer loop is the search distance from ptr; inner loop keeps every bit
  // select at a constant index so no variable-width indexing is needed.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < pN; i++) begin
      for (int j = 0; j < pN; j++) begin
        if (!found && req[j] && (j == ((int'(ptr) + i) % pN))) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tlp_tx_arbiter
// Round-robin arbiter that forwards complete TLPs from pENGINENUM engines
// onto a single core Tx interface, one packet per grant.
//   i_Clk, i_ARst          : clock, async active-high reset
//   iv_EngineReq           : engine n has a complete TLP queued
//   iv_EngineSop/Eop/Dv    : per-engine start/end/valid strobes
//   iv_EngineData          : engine n data in [n*pDW +: pDW]
//   ov_EngineGnt           : registered one-hot grant
//   ov_EngineRd            : per-engine beat-consumed strobe
//   o_TxSop/Eop/Dv/Data    : muxed Tx beat from the granted engine
//   i_TxReady              : core accepts the current beat
//   o_TimeoutErr           : one-cycle pulse when a stalled grant is aborted
//   o_Busy                 : a grant is held
//
// state | meaning
// IDLE  | no grant; picks a requester with rr_arbiter on the next edge
// XFER  | grant held until an accepted EOP beat or a stall timeout
// ---------------------------------------------------------------------------
module tlp_tx_arbiter
  import tlp_tx_pkg::*;
#(
  parameter int pENGINENUM = 4,
  parameter int pDW        = DEFAULT_DW,
  parameter int pTIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                      i_Clk,
  input  logic                      i_ARst,
  input  logic [pENGINENUM-1:0]     iv_EngineReq,
  input  logic [pENGINENUM-1:0]     iv_EngineSop,
  input  logic [pENGINENUM-1:0]     iv_EngineEop,
  input  logic [pENGINENUM-1:0]     iv_EngineDv,
  input  logic [pENGINENUM*pDW-1:0] iv_EngineData,
  output logic [pENGINENUM-1:0]     ov_EngineGnt,
  output logic [pENGINENUM-1:0]     ov_EngineRd,
  output logic                      o_TxSop,
  output logic                      o_TxEop,
  output logic                      o_TxDv,
  output logic [pDW-1:0]            o_TxData,
  input  logic                      i_TxReady,
  output logic                      o_TimeoutErr,
  output logic                      o_Busy
);

  localparam int PW = (pENGINENUM > 1) ? $clog2(pENGINENUM) : 1;

  state_e                state_q;
  logic [pENGINENUM-1:0] gnt_q;
  logic [pENGINENUM-1:0] arb_gnt;
  logic [PW-1:0]         rr_ptr_q;
  logic [PW-1:0]         rr_ptr_d;
  logic [STALL_W-1:0]    stall_q;
  logic                  err_q;
  logic [pDW-1:0]        tx_data;
  logic                  beat_acc;
  logic                  pkt_done;
  logic                  stall_tc;

  rr_arbiter #(
    .pN  (pENGINENUM),
    .pPW (PW)
  ) u_rr (
    .req (iv_EngineReq),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Data mux and the pointer that follows the current grant; both are zero
  // / unchanged when no grant is held.
  always_comb begin
    tx_data  = '0;
    rr_ptr_d = rr_ptr_q;
    for (int n = 0; n < pENGINENUM; n++) begin
      if (gnt_q[n]) begin
        tx_data  = iv_EngineData[n*pDW +: pDW];
        rr_ptr_d = (n == pENGINENUM - 1) ? '0 : PW'(n + 1);
      end
    end
  end

  // Tx strobes come straight off the registered grant, so an async reset
  // clears them in the same cycle.
  assign o_TxDv      = |(gnt_q & iv_EngineDv);
  assign o_TxSop     = |(gnt_q & iv_EngineSop);
  assign o_TxEop     = |(gnt_q & iv_EngineEop);
  assign o_TxData    = tx_data;
  assign ov_EngineRd = gnt_q & iv_EngineDv & {pENGINENUM{i_TxReady}};

  assign beat_acc = o_TxDv & i_TxReady;
  assign pkt_done = beat_acc & o_TxEop;
  // This stalled cycle is the one that brings the count to pTIMEOUT.
  assign stall_tc = !beat_acc && (stall_q == STALL_W'(pTIMEOUT - 1));

  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          stall_q <= '0;
          if (|iv_EngineReq) begin
            gnt_q   <= arb_gnt;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (pkt_done) begin
            gnt_q    <= '0;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= '0;
            state_q  <= IDLE;
          end else if (stall_tc) begin
            gnt_q    <= '0;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= '0;
            err_q    <= 1'b1;
            state_q  <= IDLE;
          end else if (beat_acc) begin
            stall_q <= '0;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ov_EngineGnt = gnt_q;
  assign o_TimeoutErr = err_q;
  assign o_Busy       = (state_q == XFER);

endmodule
